// File: rtl/spi_burst_ram_if.sv
// SPI-style serial bus between a host and spi_burst_ram.
//
// Signals:
//   SS_n - slave select, active-low; one command per low period
//   MOSI - serial data from host, MSB first
//   MISO - serial read data from the RAM, registered
//   busy - RAM frame engine is not idle
//   err  - one-cycle pulse on a frame or address error
//
// The master modport is the host side and the slave modport is the RAM side.
interface spi_burst_ram_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;
    logic err;

    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  busy,
        input  err
    );

    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output busy,
        output err
    );
endinterface

// File: rtl/spi_burst_ram.sv
// Serial-access RAM with burst write and burst read.
//
// A frame starts with a 2-bit command, MSB first:
//   00 - load the write pointer from the following ADDR_SIZE address bits
//   01 - burst write: every DATA_WIDTH bits form one word, written at wptr, wptr advances
//   10 - load the read pointer from the following ADDR_SIZE address bits
//   11 - burst read: words from rptr are shifted out on MISO MSB first, rptr advances
// The host ends a frame by raising SS_n. Pointers wrap from MEM_DEPTH-1 to 0.
//
// Ports:
//   clk - single clock, all state changes on the rising edge
//   rst - asynchronous active-high reset (memory contents are kept)
//   bus - slave side of spi_burst_ram_if (SS_n, MOSI in; MISO, busy, err out)
module spi_burst_ram #(
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    spi_burst_ram_if.slave bus
);

    localparam int unsigned MaxBits  = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
    localparam int unsigned CntWidth = $clog2(MaxBits);

    localparam logic [CntWidth-1:0]  AddrLast = CntWidth'(ADDR_SIZE - 1);
    localparam logic [CntWidth-1:0]  DataLast = CntWidth'(DATA_WIDTH - 1);
    localparam logic [ADDR_SIZE-1:0] PtrLast  = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWaddr,
        StWdata,
        StRaddr,
        StRdata
    } state_e;

    // Storage; deliberately not reset.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  cmd_hi_q, cmd_hi_d;
    logic [ADDR_SIZE-2:0]  addr_sh_q, addr_sh_d;
    logic                  addr_done_q, addr_done_d;
    logic [DATA_WIDTH-2:0] wsh_q, wsh_d;
    logic [DATA_WIDTH-2:0] rsh_q, rsh_d;
    logic                  miso_q, miso_d;
    logic                  err_q, err_d;
    logic [ADDR_SIZE-1:0]  wptr_q, wptr_d;
    logic [ADDR_SIZE-1:0]  rptr_q, rptr_d;

    logic                  ss_n;
    logic                  mosi;
    logic [ADDR_SIZE-1:0]  addr_full;
    logic                  addr_ok;
    logic [DATA_WIDTH-1:0] word_full;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [ADDR_SIZE-1:0]  wptr_inc;
    logic [ADDR_SIZE-1:0]  rptr_inc;
    logic                  mem_we;

    assign ss_n = bus.SS_n;
    assign mosi = bus.MOSI;

    // Complete address/word including the bit being sampled on this edge.
    assign addr_full = {addr_sh_q, mosi};
    assign addr_ok   = 32'(addr_full) < MEM_DEPTH;
    assign word_full = {wsh_q, mosi};

    // Zero-latency read: the word at rptr is available to the shift register on the same edge.
    assign rd_word = mem[rptr_q];

    assign wptr_inc = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
    assign rptr_inc = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_hi_d    = cmd_hi_q;
        addr_sh_d   = addr_sh_q;
        addr_done_d = addr_done_q;
        wsh_d       = wsh_q;
        rsh_d       = rsh_q;
        miso_d      = 1'b0;
        err_d       = 1'b0;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mem_we      = 1'b0;

        if (ss_n) begin
            // Frame end (or no frame): drop everything partial.
            state_d     = StIdle;
            cnt_d       = '0;
            cmd_hi_d    = 1'b0;
            addr_sh_d   = '0;
            addr_done_d = 1'b0;
            wsh_d       = '0;
            rsh_d       = '0;
            // Truncated command or partial address/word is an error; a read may stop anywhere.
            if (state_q == StCmd) begin
                err_d = 1'b1;
            end else if ((state_q == StWaddr || state_q == StRaddr || state_q == StWdata) &&
                         cnt_q != '0) begin
                err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_hi_d = mosi;
                    state_d  = StCmd;
                end

                StCmd: begin
                    cnt_d       = '0;
                    addr_done_d = 1'b0;
                    unique case ({cmd_hi_q, mosi})
                        2'b00: state_d = StWaddr;
                        2'b01: state_d = StWdata;
                        2'b10: state_d = StRaddr;
                        2'b11: begin
                            state_d = StRdata;
                            rsh_d   = rd_word[DATA_WIDTH-2:0];
                            miso_d  = rd_word[DATA_WIDTH-1];
                            rptr_d  = rptr_inc;
                        end
                    endcase
                end

                StWaddr, StRaddr: begin
                    // Once the address is taken, further bits are ignored until SS_n rises.
                    if (!addr_done_q) begin
                        if (cnt_q == AddrLast) begin
                            cnt_d       = '0;
                            addr_sh_d   = '0;
                            addr_done_d = 1'b1;
                            if (!addr_ok) begin
                                err_d = 1'b1;
                            end else if (state_q == StWaddr) begin
                                wptr_d = addr_full;
                            end else begin
                                rptr_d = addr_full;
                            end
                        end else begin
                            addr_sh_d = addr_full[ADDR_SIZE-2:0];
                            cnt_d     = cnt_q + 1'b1;
                        end
                    end
                end

                StWdata: begin
                    if (cnt_q == DataLast) begin
                        mem_we = 1'b1;
                        wptr_d = wptr_inc;
                        cnt_d  = '0;
                        wsh_d  = '0;
                    end else begin
                        wsh_d = word_full[DATA_WIDTH-2:0];
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                StRdata: begin
                    // cnt_q counts bits already shown after the MSB; at DataLast bit 0 is on MISO.
                    if (cnt_q == DataLast) begin
                        rsh_d  = rd_word[DATA_WIDTH-2:0];
                        miso_d = rd_word[DATA_WIDTH-1];
                        rptr_d = rptr_inc;
                        cnt_d  = '0;
                    end else begin
                        miso_d = rsh_q[DATA_WIDTH-2];
                        rsh_d  = rsh_q << 1;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end

                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            cmd_hi_q    <= 1'b0;
            addr_sh_q   <= '0;
            addr_done_q <= 1'b0;
            wsh_q       <= '0;
            rsh_q       <= '0;
            miso_q      <= 1'b0;
            err_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cmd_hi_q    <= cmd_hi_d;
            addr_sh_q   <= addr_sh_d;
            addr_done_q <= addr_done_d;
            wsh_q       <= wsh_d;
            rsh_q       <= rsh_d;
            miso_q      <= miso_d;
            err_q       <= err_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= word_full;
        end
    end

    assign bus.MISO = miso_q;
    assign bus.busy = (state_q != StIdle);
    assign bus.err  = err_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Bench for spi_burst_ram: one default instance (u_a) and one with MEM_DEPTH=200 (u_b).
// Stimulus drives a shared SS_n/MOSI; sel picks which instance sees SS_n low.
// Read words are pushed to a queue when a read burst is issued; a monitor assembles
// MISO bits into words and pops/compares, and also tracks err pulses and MISO idle level.
module tb_spi_burst_ram;

    logic clk = 1'b0;
    logic rst;
    logic ss_n;
    logic mosi;
    logic sel;

    always #5 clk = ~clk;

    spi_burst_ram_if bus_a ();
    spi_burst_ram_if bus_b ();

    assign bus_a.SS_n = ss_n | sel;
    assign bus_b.SS_n = ss_n | ~sel;
    assign bus_a.MOSI = mosi;
    assign bus_b.MOSI = mosi;

    spi_burst_ram u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    spi_burst_ram #(
        .MEM_DEPTH  (200),
        .ADDR_SIZE  (8),
        .DATA_WIDTH (8)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic miso_m, busy_m, err_m;
    assign miso_m = sel ? bus_b.MISO : bus_a.MISO;
    assign busy_m = sel ? bus_b.busy : bus_a.busy;
    assign err_m  = sel ? bus_b.err  : bus_a.err;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    logic rd_active = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        logic [7:0] acc;
        logic [7:0] e;
        int nbits;
        logic err_prev;
        acc = '0;
        nbits = 0;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_active) begin
                acc = {acc[6:0], miso_m};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        check("rd_unexpected_word", 32'(acc), 32'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_word", 32'(acc), 32'(e));
                    end
                end
            end else begin
                check("miso_idle", 32'(miso_m), 32'd0);
            end
            if (err_m) begin
                err_cnt++;
                if (err_prev) check("err_width", 32'd2, 32'd1);
            end
            err_prev = err_m;
        end
    end

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            ss_n = 1'b0;
            mosi = val[i];
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_waddr(input logic [7:0] a);
        send_bits({22'd0, 2'b00, a}, 10);
        end_frame();
    endtask

    task automatic write_words(input logic [7:0] w0, input logic [7:0] w1, input int n);
        send_bits(32'b01, 2);
        send_bits(32'(w0), 8);
        if (n > 1) send_bits(32'(w1), 8);
        end_frame();
    endtask

    task automatic read_words(input logic [7:0] a, input logic [7:0] w0, input logic [7:0] w1,
                              input int n);
        send_bits({22'd0, 2'b10, a}, 10);
        end_frame();
        exp_q.push_back(w0);
        if (n > 1) exp_q.push_back(w1);
        send_bits(32'b11, 2);
        @(posedge clk);
        #1 rd_active = 1'b1;
        repeat (8 * n) @(negedge clk);
        #1;
        rd_active = 1'b0;
        ss_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        sel  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus_a.busy), 0);
        check("rst_err", 32'(bus_a.err), 0);
        check("rst_miso", 32'(bus_a.MISO), 0);
        check("rst_wptr", 32'(u_a.wptr_q), 0);
        check("rst_rptr", 32'(u_a.rptr_q), 0);
        check("rst_wptr_b", 32'(u_b.wptr_q), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic burst write then burst read.
        set_waddr(8'h10);
        write_words(8'hA5, 8'h3C, 2);
        check("wr_mem10", 32'(u_a.mem[8'h10]), 32'hA5);
        check("wr_mem11", 32'(u_a.mem[8'h11]), 32'h3C);
        check("wr_wptr", 32'(u_a.wptr_q), 32'h12);
        check("wr_err_cnt", 32'(err_cnt), 0);
        read_words(8'h10, 8'hA5, 8'h3C, 2);
        check("rd_rptr", 32'(u_a.rptr_q), 32'h12);
        check("rd_err_cnt", 32'(err_cnt), 0);

        // Pointer wrap at the top of a 256-word memory.
        set_waddr(8'hFF);
        write_words(8'h11, 8'h22, 2);
        check("wrap_mem_ff", 32'(u_a.mem[8'hFF]), 32'h11);
        check("wrap_mem_00", 32'(u_a.mem[8'h00]), 32'h22);
        check("wrap_wptr", 32'(u_a.wptr_q), 1);
        read_words(8'hFF, 8'h11, 8'h22, 2);
        check("wrap_rptr", 32'(u_a.rptr_q), 1);

        // Partial word aborted by SS_n: err pulse, no write.
        set_waddr(8'h20);
        write_words(8'h5A, 8'h00, 1);
        check("pw_wptr_pre", 32'(u_a.wptr_q), 32'h21);
        set_waddr(8'h20);
        send_bits(32'b01, 2);
        send_bits(32'b10101, 5);
        @(negedge clk);
        ss_n = 1'b1;
        @(negedge clk);
        #1;
        check("pw_err_high", 32'(err_m), 1);
        check("pw_busy_low", 32'(busy_m), 0);
        @(negedge clk);
        #1;
        check("pw_err_low", 32'(err_m), 0);
        check("pw_err_cnt", 32'(err_cnt), 1);
        check("pw_wptr", 32'(u_a.wptr_q), 32'h20);
        check("pw_mem20", 32'(u_a.mem[8'h20]), 32'h5A);
        read_words(8'h20, 8'h5A, 8'h00, 1);

        // MEM_DEPTH=200 instance: out-of-range address, then wrap at 199.
        sel = 1'b1;
        set_waddr(8'hC8);
        check("oor_err_cnt", 32'(err_cnt), 2);
        check("oor_wptr", 32'(u_b.wptr_q), 0);
        set_waddr(8'hC7);
        write_words(8'h77, 8'h88, 2);
        check("d200_mem_c7", 32'(u_b.mem[8'hC7]), 32'h77);
        check("d200_mem_00", 32'(u_b.mem[8'h00]), 32'h88);
        check("d200_wptr", 32'(u_b.wptr_q), 1);
        read_words(8'hC7, 8'h77, 8'h88, 2);
        check("d200_rptr", 32'(u_b.rptr_q), 1);
        check("d200_err_cnt", 32'(err_cnt), 2);
        sel = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write word.
        set_waddr(8'h30);
        write_words(8'h44, 8'h00, 1);
        set_waddr(8'h31);
        send_bits(32'b01, 2);
        send_bits(32'hB, 4);
        #1;
        check("mid_busy", 32'(bus_a.busy), 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus_a.busy), 0);
        check("mid_rst_miso", 32'(bus_a.MISO), 0);
        check("mid_rst_err", 32'(bus_a.err), 0);
        check("mid_rst_wptr", 32'(u_a.wptr_q), 0);
        ss_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_mem30", 32'(u_a.mem[8'h30]), 32'h44);
        check("mid_err_cnt", 32'(err_cnt), 2);
        set_waddr(8'h31);
        write_words(8'h99, 8'h00, 1);
        read_words(8'h30, 8'h44, 8'h99, 2);
        check("end_err_cnt", 32'(err_cnt), 2);
        check("end_queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
